// File: rtl/uni_shift_pkg.sv
// Shared constants for the universal shift register sequencer: register mode
// codes and the controller state encoding.
package uni_shift_pkg;

   localparam logic [1:0] S_HOLD = 2'b00;
   localparam logic [1:0] S_SHR  = 2'b01;
   localparam logic [1:0] S_SHL  = 2'b10;
   localparam logic [1:0] S_LOAD = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      LOAD  = 2'b01,
      SHIFT = 2'b10,
      DONE  = 2'b11
   } state_e;

endpackage

// File: rtl/uni_shiftreg.sv
// N-bit universal shift register: hold, shift right, shift left, parallel load.
// Serial outputs expose the bit that falls off each end.
module uni_shiftreg
   import uni_shift_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [1:0]   s,
   input  logic [N-1:0] pin,
   input  logic         sin_left,
   input  logic         sin_right,
   output logic [N-1:0] q,
   output logic         sout_left,
   output logic         sout_right
);

   logic [N-1:0] q_q;
   logic [N:0]   shl_w;
   logic [N:0]   shr_w;

   // Widened concatenations keep both shifts legal for N == 1.
   assign shl_w = {q_q, sin_right};
   assign shr_w = {sin_left, q_q};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q <= '0;
      end else begin
         case (s)
            S_SHR:   q_q <= shr_w[N:1];
            S_SHL:   q_q <= shl_w[N-1:0];
            S_LOAD:  q_q <= pin;
            default: q_q <= q_q;
         endcase
      end
   end

   assign q          = q_q;
   assign sout_left  = q_q[N-1];
   assign sout_right = q_q[0];

endmodule

// File: rtl/uni_shift_ctrl.sv
// Word serializer sequencer for uni_shiftreg: one LOAD, N shifts in the
// requested direction, then a one-cycle done pulse. All outputs but in_ready are registered.
module uni_shift_ctrl
   import uni_shift_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic         in_dir,
   input  logic         in_fill,
   input  logic         abort,
   output logic [1:0]   s,
   output logic [N-1:0] pin,
   output logic         sin_left,
   output logic         sin_right,
   output logic         busy,
   output logic         done
);

   localparam int CNT_W = $clog2(N) + 1;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             dir_q;
   logic             fill_q;
   logic [1:0]       s_q;
   logic [N-1:0]     pin_q;
   logic             sin_left_q;
   logic             sin_right_q;
   logic             busy_q;
   logic             done_q;
   logic             accept;

   assign in_ready = ((state_q == IDLE) || (state_q == DONE)) && !abort;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         dir_q       <= 1'b0;
         fill_q      <= 1'b0;
         s_q         <= S_HOLD;
         pin_q       <= '0;
         sin_left_q  <= 1'b0;
         sin_right_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               state_q     <= IDLE;
               s_q         <= S_HOLD;
               sin_left_q  <= 1'b0;
               sin_right_q <= 1'b0;
               busy_q      <= 1'b0;
               done_q      <= 1'b0;
               if (accept) begin
                  state_q <= LOAD;
                  s_q     <= S_LOAD;
                  busy_q  <= 1'b1;
                  pin_q   <= in_data;
                  dir_q   <= in_dir;
                  fill_q  <= in_fill;
                  cnt_q   <= CNT_W'(N - 1);
               end
            end
            LOAD: begin
               if (abort) begin
                  state_q <= IDLE;
                  s_q     <= S_HOLD;
                  busy_q  <= 1'b0;
               end else begin
                  state_q     <= SHIFT;
                  s_q         <= dir_q ? S_SHL : S_SHR;
                  sin_left_q  <= !dir_q && fill_q;
                  sin_right_q <= dir_q && fill_q;
               end
            end
            SHIFT: begin
               // Counter starts at N-1, so the zero test yields exactly N shift cycles.
               if (abort || (cnt_q == '0)) begin
                  state_q     <= abort ? IDLE : DONE;
                  s_q         <= S_HOLD;
                  sin_left_q  <= 1'b0;
                  sin_right_q <= 1'b0;
                  busy_q      <= 1'b0;
                  done_q      <= !abort;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign s         = s_q;
   assign pin       = pin_q;
   assign sin_left  = sin_left_q;
   assign sin_right = sin_right_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_uni_shift_ctrl.sv
// Sequencer + shift register back to back; per-cycle expectations come from a
// schedule queue built when each word is accepted.
module tb_uni_shift_ctrl;

   localparam int N = 4;

   logic         clk, reset;
   logic         in_valid, in_ready, in_dir, in_fill, abort;
   logic [N-1:0] in_data, pin, q;
   logic [1:0]   s;
   logic         sin_left, sin_right, busy, done, sout_left, sout_right;

   uni_shift_ctrl #(.N(N)) u_ctrl (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_dir(in_dir), .in_fill(in_fill), .abort(abort),
      .s(s), .pin(pin), .sin_left(sin_left), .sin_right(sin_right),
      .busy(busy), .done(done)
   );

   uni_shiftreg #(.N(N)) u_sreg (
      .clk(clk), .reset(reset), .s(s), .pin(pin), .sin_left(sin_left),
      .sin_right(sin_right), .q(q), .sout_left(sout_left), .sout_right(sout_right)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum {K_IDLE, K_LOAD, K_SHIFT, K_DONE} kind_e;
   typedef struct {
      kind_e k;
      int    j;
      int    data;
      bit    dir;
      bit    fill;
   } ent_t;

   ent_t expq[$];
   ent_t cur;
   int   last_q, last_pin;
   int   n_chk, n_pass;
   bit   pend;
   int   w_data;
   bit   w_dir, w_fill;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   // Register contents after j shifts of word d: j fill bits enter, j data bits leave.
   function automatic int partial(int d, bit dir, bit fill, int j);
      int m;
      m = (1 << N) - 1;
      if (!dir) return (d >> j) | (fill ? ((m << (N - j)) & m) : 0);
      else      return ((d << j) & m) | (fill ? ((1 << j) - 1) : 0);
   endfunction

   task automatic check_outputs();
      int es, eb, ed, esl, esr;
      es = 0; eb = 0; ed = 0; esl = 0; esr = 0;
      case (cur.k)
         K_LOAD:  begin es = 3; eb = 1; end
         K_SHIFT: begin
            es  = cur.dir ? 2 : 1;
            eb  = 1;
            esl = (!cur.dir && cur.fill) ? 1 : 0;
            esr = (cur.dir && cur.fill) ? 1 : 0;
         end
         K_DONE:  ed = 1;
         default: ;
      endcase
      chk("s", int'(s), es);
      chk("busy", int'(busy), eb);
      chk("done", int'(done), ed);
      chk("sin_left", int'(sin_left), esl);
      chk("sin_right", int'(sin_right), esr);
      chk("q", int'(q), last_q);
      chk("pin", int'(pin), (cur.k == K_LOAD) ? cur.data : last_pin);
      if (cur.k == K_SHIFT) begin
         if (!cur.dir) chk("sout_right", int'(sout_right), (cur.data >> cur.j) & 1);
         else          chk("sout_left", int'(sout_left), (cur.data >> (N - 1 - cur.j)) & 1);
      end
      if (cur.k == K_DONE) chk("q_final", int'(q), cur.fill ? (1 << N) - 1 : 0);
   endtask

   // One clock: check this cycle's outputs, drive next inputs, check in_ready.
   task automatic step(input int p_valid, input int p_abort, input int abort_j);
      bit rdy;
      @(posedge clk);
      #1;
      if (expq.size() > 0) cur = expq.pop_front();
      else cur = '{K_IDLE, 0, 0, 1'b0, 1'b0};
      check_outputs();
      if (cur.k == K_LOAD) begin
         last_pin = cur.data;
         last_q   = cur.data;
      end else if (cur.k == K_SHIFT) begin
         last_q = partial(cur.data, cur.dir, cur.fill, cur.j + 1);
      end
      if (!pend && ($urandom_range(99) < p_valid)) begin
         pend   = 1'b1;
         w_data = $urandom_range((1 << N) - 1);
         w_dir  = 1'($urandom_range(1));
         w_fill = 1'($urandom_range(1));
      end
      in_valid = pend;
      in_data  = N'(w_data);
      in_dir   = w_dir;
      in_fill  = w_fill;
      abort    = ($urandom_range(99) < p_abort) ||
                 (cur.k == K_SHIFT && cur.j == abort_j);
      #1;
      rdy = (cur.k == K_IDLE || cur.k == K_DONE) && !abort;
      chk("in_ready", int'(in_ready), int'(rdy));
      if (abort && (cur.k == K_LOAD || cur.k == K_SHIFT)) expq.delete();
      if (in_valid && rdy) begin
         pend = 1'b0;
         expq.push_back('{K_LOAD, 0, w_data, w_dir, w_fill});
         for (int i = 0; i < N; i++) expq.push_back('{K_SHIFT, i, w_data, w_dir, w_fill});
         expq.push_back('{K_DONE, N, w_data, w_dir, w_fill});
      end
   endtask

   task automatic set_word(input int d, input bit dir, input bit fill);
      pend = 1'b1; w_data = d; w_dir = dir; w_fill = fill;
   endtask

   initial begin
      n_chk = 0; n_pass = 0; last_q = 0; last_pin = 0; pend = 1'b0;
      w_data = 0; w_dir = 1'b0; w_fill = 1'b0;
      reset = 1'b1; in_valid = 1'b0; in_data = '0; in_dir = 1'b0;
      in_fill = 1'b0; abort = 1'b0;
      cur = '{K_IDLE, 0, 0, 1'b0, 1'b0};
      #12;
      check_outputs();
      chk("in_ready_rst", int'(in_ready), 1);
      #3;
      @(negedge clk) reset = 1'b0;
      for (int i = 0; i < 3; i++) step(0, 0, -1);

      set_word(4'b1010, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) step(0, 0, -1);
      set_word(4'b0011, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) step(0, 0, -1);
      for (int i = 0; i < 14; i++) step(100, 0, -1);
      for (int i = 0; i < 6; i++) step(0, 0, -1);
      set_word(4'b1101, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(0, 0, 1);

      // Reset in the middle of a word, then a fresh word must still complete.
      set_word(4'b0110, 1'b1, 1'b1);
      for (int i = 0; i < 10 && cur.k != K_SHIFT; i++) step(0, 0, -1);
      chk("reached_shift", int'(cur.k == K_SHIFT), 1);
      pend = 1'b0; in_valid = 1'b0; abort = 1'b0;
      #1 reset = 1'b1;
      #1;
      expq.delete();
      last_q = 0; last_pin = 0;
      cur = '{K_IDLE, 0, 0, 1'b0, 1'b0};
      check_outputs();
      chk("in_ready_midrst", int'(in_ready), 1);
      @(negedge clk) reset = 1'b0;
      set_word(4'b1001, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) step(0, 0, -1);

      for (int i = 0; i < 600; i++) step(60, 5, -1);
      for (int i = 0; i < 8; i++) step(0, 0, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
